// File: rtl/freq_div_scheduler_pkg.sv
// Shared types and default widths for the frequency-divider scheduler.
// State encoding is fixed so the 3-bit value can be read directly on a probe.
package freq_div_sched_pkg;

    localparam int DIV_W_DEF = 32;
    localparam int DUR_W_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_STOP = 3'd1,
        ST_LOAD = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/freq_div_scheduler_if.sv
// Requester-side bus of the scheduler: per-requester valid/divisor/duration
// going in, one-hot grant and done pulses coming back.
interface freq_div_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DIV_W   = 32,
    parameter int DUR_W   = 16
);
    logic [NUM_REQ-1:0]       ReqValid;
    logic [NUM_REQ*DIV_W-1:0] ReqDiv;
    logic [NUM_REQ*DUR_W-1:0] ReqDuration;
    logic [NUM_REQ-1:0]       ReqGrant;
    logic [NUM_REQ-1:0]       ReqDone;

    modport master (
        output ReqValid, ReqDiv, ReqDuration,
        input  ReqGrant, ReqDone
    );

    modport slave (
        input  ReqValid, ReqDiv, ReqDuration,
        output ReqGrant, ReqDone
    );
endinterface

// File: rtl/freq_div_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
// ptr is always kept below N by the caller.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_req
);
    int   idx;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = |req;
        found     = 1'b0;
        idx       = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found          = 1'b1;
                grant[idx]     = 1'b1;
                grant_idx      = IW'(idx);
            end
        end
    end
endmodule

// File: rtl/freq_div_scheduler.sv
// Time-shares one frequency divider between NUM_REQ requesters: pick one
// round-robin, stop the divider, load its divisor, run it for N cycles, ack.
module freq_div_scheduler
    import freq_div_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DIV_W   = DIV_W_DEF,
    parameter int DUR_W   = DUR_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    freq_div_scheduler_if.slave req_if,
    output logic [DIV_W-1:0]  DivDin,
    output logic              DivConfig,
    output logic              DivEnable,
    output logic              Busy
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DUR_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [DIV_W-1:0]   din_q, din_d;
    logic               cfg_q, cfg_d;
    logic               en_q, en_d;
    logic               busy_q, busy_d;

    logic [NUM_REQ-1:0] win_oh;
    logic [IDX_W-1:0]   win_idx;
    logic               any_req;
    logic [DIV_W-1:0]   sel_div;
    logic [DUR_W-1:0]   sel_dur;
    logic               aborting;
    logic [IDX_W-1:0]   next_ptr;

    rr_arbiter #(.N(NUM_REQ), .IW(IDX_W)) u_arb (
        .req       (req_if.ReqValid),
        .ptr       (ptr_q),
        .grant     (win_oh),
        .grant_idx (win_idx),
        .any_req   (any_req)
    );

    always_comb begin
        sel_div = '0;
        sel_dur = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                sel_div = sel_div | req_if.ReqDiv[i*DIV_W +: DIV_W];
                sel_dur = sel_dur | req_if.ReqDuration[i*DUR_W +: DUR_W];
            end
        end
    end

    assign next_ptr = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;
    assign aborting = (state_q inside {ST_STOP, ST_LOAD, ST_RUN}) && !req_if.ReqValid[gidx_q];

    // Outputs are computed for the state being entered, so once registered
    // they line up with that state's cycle.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        done_d  = '0;
        din_d   = din_q;
        cfg_d   = 1'b0;
        en_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_STOP;
                    gidx_d  = win_idx;
                    grant_d = win_oh;
                    div_d   = sel_div;
                    cnt_d   = sel_dur;
                end
            end
            ST_STOP: begin
                state_d = ST_LOAD;
                cfg_d   = 1'b1;
                din_d   = div_q;
            end
            ST_LOAD: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                    done_d  = grant_q;
                end else begin
                    state_d = ST_RUN;
                    en_d    = 1'b1;
                end
            end
            ST_RUN: begin
                if (cnt_q == DUR_W'(1)) begin
                    state_d = ST_DONE;
                    done_d  = grant_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    en_d  = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = '0;
                din_d   = '0;
                ptr_d   = next_ptr;
            end
            default: state_d = ST_IDLE;
        endcase

        // A requester withdrawing mid-service wins over any normal transition.
        if (aborting) begin
            state_d = ST_IDLE;
            grant_d = '0;
            done_d  = '0;
            din_d   = '0;
            cfg_d   = 1'b0;
            en_d    = 1'b0;
            ptr_d   = next_ptr;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            done_q  <= '0;
            din_q   <= '0;
            cfg_q   <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            din_q   <= din_d;
            cfg_q   <= cfg_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
        end
    end

    assign req_if.ReqGrant = grant_q;
    assign req_if.ReqDone  = done_q;
    assign DivDin          = din_q;
    assign DivConfig       = cfg_q;
    assign DivEnable       = en_q;
    assign Busy            = busy_q;
endmodule

// File: tb/tb_freq_div_scheduler.sv
// Directed bench for freq_div_scheduler: timeline, round-robin order,
// zero duration, abort, async reset mid-run, plus exclusivity/one-hot monitors.
module tb_freq_div_scheduler;
    localparam int NR = 4;
    localparam int DW = 32;
    localparam int UW = 16;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic [DW-1:0] DivDin;
    logic          DivConfig, DivEnable, Busy;

    int errors = 0;
    int checks = 0;
    int excl_bad = 0;
    int oh_bad = 0;

    freq_div_scheduler_if #(.NUM_REQ(NR), .DIV_W(DW), .DUR_W(UW)) rif ();

    freq_div_scheduler #(.NUM_REQ(NR), .DIV_W(DW), .DUR_W(UW)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .req_if    (rif),
        .DivDin    (DivDin),
        .DivConfig (DivConfig),
        .DivEnable (DivEnable),
        .Busy      (Busy)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (!Reset) begin
            if (DivConfig && DivEnable) excl_bad++;
            if ($countones(rif.ReqGrant) > 1) oh_bad++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge Clk);
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] d, input logic [UW-1:0] du);
        rif.ReqDiv[i*DW +: DW]      = d;
        rif.ReqDuration[i*UW +: UW] = du;
    endtask

    task automatic do_reset();
        Reset        = 1'b1;
        rif.ReqValid = '0;
        cyc();
        cyc();
        Reset = 1'b0;
    endtask

    task automatic wait_grant(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            cyc();
            n++;
        end while (rif.ReqGrant == '0 && n < budget);
        if (rif.ReqGrant == '0) check({tag, "_timeout"}, 64'd1, 64'd0);
    endtask

    initial begin
        int en_cnt;
        int exp_order [5] = '{0, 1, 2, 3, 0};
        logic [NR-1:0] exp_oh;

        rif.ReqValid    = '0;
        rif.ReqDiv      = '0;
        rif.ReqDuration = '0;

        // Reset values
        Reset = 1'b1;
        cyc();
        check("rst_grant", rif.ReqGrant, 0);
        check("rst_done", rif.ReqDone, 0);
        check("rst_din", DivDin, 0);
        check("rst_cfg", DivConfig, 0);
        check("rst_en", DivEnable, 0);
        check("rst_busy", Busy, 0);

        // Single request, Div=4, Dur=8
        do_reset();
        set_req(0, 4, 8);
        rif.ReqValid = 4'b0001;
        cyc();
        check("t1_grant_k1", rif.ReqGrant, 4'b0001);
        check("t1_busy_k1", Busy, 1);
        check("t1_en_k1", DivEnable, 0);
        set_req(0, 9, 3);
        cyc();
        check("t1_cfg_k2", DivConfig, 1);
        check("t1_din_k2", DivDin, 4);
        check("t1_en_k2", DivEnable, 0);
        en_cnt = 0;
        for (int n = 3; n <= 10; n++) begin
            cyc();
            if (DivEnable) en_cnt++;
        end
        check("t1_en_cycles", en_cnt, 8);
        cyc();
        check("t1_done_k11", rif.ReqDone, 4'b0001);
        check("t1_en_k11", DivEnable, 0);
        check("t1_din_k11", DivDin, 4);
        check("t1_grant_k11", rif.ReqGrant, 4'b0001);
        rif.ReqValid = '0;
        cyc();
        check("t1_done_k12", rif.ReqDone, 0);
        check("t1_grant_k12", rif.ReqGrant, 0);
        check("t1_busy_k12", Busy, 0);
        check("t1_din_k12", DivDin, 0);

        // All four requesting continuously, Dur=2 each
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 32'(i + 2), 2);
        rif.ReqValid = 4'b1111;
        for (int s = 0; s < 5; s++) begin
            exp_oh = NR'(1) << exp_order[s];
            wait_grant("t2", 8);
            check("t2_grant_order", rif.ReqGrant, exp_oh);
            en_cnt = 0;
            for (int n = 0; n < 4; n++) begin
                cyc();
                if (DivEnable) en_cnt++;
            end
            check("t2_en_cycles", en_cnt, 2);
            check("t2_done", rif.ReqDone, exp_oh);
            cyc();
            check("t2_done_pulse", rif.ReqDone, 0);
        end
        rif.ReqValid = '0;

        // Zero duration: config pulse, never enabled, done at k+3
        do_reset();
        set_req(1, 7, 0);
        rif.ReqValid = 4'b0010;
        en_cnt = 0;
        cyc();
        if (DivEnable) en_cnt++;
        check("t3_grant", rif.ReqGrant, 4'b0010);
        cyc();
        if (DivEnable) en_cnt++;
        check("t3_cfg", DivConfig, 1);
        check("t3_din", DivDin, 7);
        cyc();
        if (DivEnable) en_cnt++;
        check("t3_done_k3", rif.ReqDone, 4'b0010);
        check("t3_cfg_k3", DivConfig, 0);
        rif.ReqValid = '0;
        cyc();
        if (DivEnable) en_cnt++;
        check("t3_en_never", en_cnt, 0);
        check("t3_busy_after", Busy, 0);

        // Abort: requester 2 drops at its 3rd RUN cycle
        do_reset();
        set_req(2, 3, 10);
        set_req(3, 5, 5);
        set_req(0, 6, 4);
        rif.ReqValid = 4'b0100;
        cyc();
        check("t4_grant", rif.ReqGrant, 4'b0100);
        cyc();
        cyc();
        cyc();
        cyc();
        check("t4_en_run3", DivEnable, 1);
        rif.ReqValid = 4'b1001;
        cyc();
        check("t4_en_after", DivEnable, 0);
        check("t4_grant_after", rif.ReqGrant, 0);
        check("t4_no_done", rif.ReqDone, 0);
        check("t4_busy_after", Busy, 0);
        cyc();
        check("t4_next_is_3", rif.ReqGrant, 4'b1000);
        check("t4_no_done2", rif.ReqDone, 0);

        // Async reset mid-RUN of requester 3
        cyc();
        cyc();
        check("t5_en_run", DivEnable, 1);
        Reset = 1'b1;
        #1;
        check("t5_en_async", DivEnable, 0);
        check("t5_grant_async", rif.ReqGrant, 0);
        check("t5_busy_async", Busy, 0);
        check("t5_din_async", DivDin, 0);
        cyc();
        Reset = 1'b0;
        cyc();
        check("t5_first_after_rst", rif.ReqGrant, 4'b0001);
        rif.ReqValid = '0;
        cyc();

        check("inv_cfg_en_exclusive", excl_bad, 0);
        check("inv_grant_onehot", oh_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
